weight_rom_arbiter: RTL and testbench

- Shares one synchronous weight/bias ROM read port between `NUM_REQ` layer engines, e.g. two cascaded Dense layers, or a Conv and a Dense layer.
- Arbitrates per read with a round-robin pointer. A requester can lock the port across a burst.
- Tags each read in flight and routes the returned ROM word back to its requester with a per-requester valid pulse.
- Sits between the layer datapaths' `weightAdr`/`biasAdr` outputs and the single ROM instance.

---
 rtl/weight_rom_arbiter_pkg.sv | 51 +++++
 rtl/weight_rom_arbiter_rd_tag_pipe.sv | 29 ++
 rtl/weight_rom_arbiter.sv | 118 +++++++++++
 tb/tb_weight_rom_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_rom_arbiter_pkg.sv
// Shared types, default widths and the round-robin pick helper for the weight ROM arbiter.
// Latency: n/a (types and combinational helper only).
// Backpressure: n/a.
package weight_rom_arbiter_pkg;

  localparam int NUM_REQ_DEF     = 2;
  localparam int ADR_WIDTH_DEF   = 16;
  localparam int DATA_SIZE_DEF   = 16;
  localparam int ROM_LATENCY_DEF = 1;

  // Index fields are sized for the largest supported requester count so that
  // the tag struct and the pick helper stay independent of NUM_REQ.
  localparam int MAX_REQ = 16;
  localparam int IDX_W   = $clog2(MAX_REQ);

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef struct packed {
    logic     valid;
    req_idx_t index;
  } tag_t;

  typedef struct packed {
    logic     found;
    req_idx_t index;
  } pick_t;

  // First requester at or after ptr, wrapping modulo n. The loop runs from the
  // far end downwards so the nearest hit is written last and wins.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                    input req_idx_t           ptr,
                                    input int                 n);
    pick_t    pick;
    int       sum;
    req_idx_t idx;
    pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        sum = int'(ptr) + k;
        if (sum >= n) sum = sum - n;
        idx = req_idx_t'(sum);
        if (req[idx]) begin
          pick.found = 1'b1;
          pick.index = idx;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/weight_rom_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, requester} tags alongside ROM reads.
// Latency: DEPTH cycles from push to pop.
// Backpressure: none; advances every cycle, synchronous clear drops all tags.
module rd_tag_pipe
  import weight_rom_arbiter_pkg::*;
#(
  parameter int DEPTH = ROM_LATENCY_DEF
) (
  input  logic clk,
  input  logic rst,
  input  tag_t push,
  output tag_t pop
);

  tag_t stage [DEPTH];

  // Shift tags one stage per cycle; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
    end else begin
      stage[0] <= push;
      for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
    end
  end

  assign pop = stage[DEPTH-1];

endmodule

// File: rtl/weight_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous weight/bias ROM read port between layer engines, with burst lock.
// Latency: grant/romRd combinational in the request cycle; rvalid ROM_LATENCY cycles after accept.
// Backpressure: losers and non-owners see gnt low and must hold req; returns cannot be stalled.
module weight_rom_arbiter
  import weight_rom_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = NUM_REQ_DEF,
  parameter int ADR_WIDTH   = ADR_WIDTH_DEF,
  parameter int DATA_SIZE   = DATA_SIZE_DEF,
  parameter int ROM_LATENCY = ROM_LATENCY_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             lock,
  input  logic [NUM_REQ*ADR_WIDTH-1:0]   reqAdr,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           romRd,
  output logic [ADR_WIDTH-1:0]           romAdr,
  input  logic [DATA_SIZE-1:0]           romData,
  output logic [DATA_SIZE-1:0]           rdata,
  output logic [NUM_REQ-1:0]             rvalid
);

  logic                 owner_vld;
  req_idx_t             owner_idx;
  req_idx_t             rr_ptr;

  pick_t                pick;
  logic                 acc;
  req_idx_t             acc_idx;
  logic                 acc_lock;
  logic [ADR_WIDTH-1:0] acc_adr;
  logic                 lock_owner;
  tag_t                 push_tag;
  tag_t                 pop_tag;

  // Grant: the owner alone while a lock is held, otherwise nearest requester from rr_ptr.
  always_comb begin
    gnt  = '0;
    pick = rr_pick(MAX_REQ'(req), rr_ptr, NUM_REQ);
    if (!rst) begin
      if (owner_vld) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (owner_idx == req_idx_t'(i)) gnt[i] = req[i];
        end
      end else begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if (pick.found && pick.index == req_idx_t'(i)) gnt[i] = 1'b1;
        end
      end
    end
  end

  // Accept decode: gnt already implies req, so any grant bit is an accepted read.
  always_comb begin
    acc        = 1'b0;
    acc_idx    = '0;
    acc_lock   = 1'b0;
    acc_adr    = '0;
    lock_owner = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        acc      = 1'b1;
        acc_idx  = req_idx_t'(i);
        acc_lock = lock[i];
        acc_adr  = reqAdr[i*ADR_WIDTH +: ADR_WIDTH];
      end
      if (owner_idx == req_idx_t'(i)) lock_owner = lock[i];
    end
  end

  assign romRd          = acc;
  assign romAdr         = acc_adr;
  assign push_tag.valid = acc;
  assign push_tag.index = acc_idx;

  // Pointer advances past each accepted requester; ownership is taken on a locked accept and dropped on the first unlocked cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_vld <= 1'b0;
      owner_idx <= '0;
      rr_ptr    <= '0;
    end else begin
      if (acc) begin
        rr_ptr <= (acc_idx == req_idx_t'(NUM_REQ - 1)) ? '0 : acc_idx + req_idx_t'(1);
      end
      if (owner_vld) begin
        if (!lock_owner) owner_vld <= 1'b0;
      end else if (acc && acc_lock) begin
        owner_vld <= 1'b1;
        owner_idx <= acc_idx;
      end
    end
  end

  rd_tag_pipe #(
    .DEPTH (ROM_LATENCY)
  ) u_tag_pipe (
    .clk  (clk),
    .rst  (rst),
    .push (push_tag),
    .pop  (pop_tag)
  );

  // Return routing: the tag leaving the pipe lines up with the ROM word for that read.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    if (!rst && pop_tag.valid) begin
      rdata = romData;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pop_tag.index == req_idx_t'(i)) rvalid[i] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_weight_rom_arbiter.sv
module tb_weight_rom_arbiter;

  localparam int N  = 3;
  localparam int L  = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*AW-1:0] reqAdr;
  logic [N-1:0]    gnt;
  logic            romRd;
  logic [AW-1:0]   romAdr;
  logic [DW-1:0]   romData;
  logic [DW-1:0]   rdata;
  logic [N-1:0]    rvalid;

  always #5 clk = ~clk;

  weight_rom_arbiter #(
    .NUM_REQ(N), .ADR_WIDTH(AW), .DATA_SIZE(DW), .ROM_LATENCY(L)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .reqAdr(reqAdr),
    .gnt(gnt), .romRd(romRd), .romAdr(romAdr), .romData(romData),
    .rdata(rdata), .rvalid(rvalid)
  );

  // Synchronous ROM with L cycles of read latency; word = address + 0x100.
  logic [DW-1:0] rom_pipe [L];
  always @(posedge clk) begin
    rom_pipe[0] <= romRd ? (romAdr + 16'h0100) : 16'hdead;
    for (int s = 1; s < L; s++) rom_pipe[s] <= rom_pipe[s-1];
  end
  assign romData = rom_pipe[L-1];

  // Reference model: owner (-1 = none), pointer, and a list of expected returns.
  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } ret_t;

  ret_t ret_q[$];
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   cyc     = 0;
  int   errors  = 0;
  int   checks  = 0;

  // One clock: drive at negedge, compare against the model, update model at posedge.
  task automatic cycle(input logic rs, input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N*AW-1:0] adr,
                       output logic [N-1:0] g_o, output logic rd_o,
                       output logic [N-1:0] rv_o, output logic [DW-1:0] dat_o);
    logic [N-1:0]  eg;
    logic [N-1:0]  erv;
    logic [AW-1:0] eadr;
    logic [DW-1:0] edat;
    int            a;
    ret_t          e;
    @(negedge clk);
    rst = rs; req = r; lock = l; reqAdr = adr;
    #1;
    a = -1;
    if (!rs) begin
      if (m_owner >= 0) begin
        if (r[m_owner]) a = m_owner;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (a < 0 && r[j]) a = j;
        end
      end
    end
    eg = '0;
    eadr = '0;
    if (a >= 0) begin
      eg[a] = 1'b1;
      eadr = adr[a*AW +: AW];
    end
    erv = '0;
    edat = '0;
    if (!rs && ret_q.size() > 0 && ret_q[0].due == cyc) begin
      erv[ret_q[0].idx] = 1'b1;
      edat = ret_q[0].data;
      void'(ret_q.pop_front());
    end
    checks++; if (gnt !== eg) begin errors++; $display("FAIL gnt cyc=%0d got %b want %b", cyc, gnt, eg); end
    checks++; if (romRd !== (a >= 0)) begin errors++; $display("FAIL romRd cyc=%0d got %b want %b", cyc, romRd, (a >= 0)); end
    checks++; if (romAdr !== eadr) begin errors++; $display("FAIL romAdr cyc=%0d got %h want %h", cyc, romAdr, eadr); end
    checks++; if (rvalid !== erv) begin errors++; $display("FAIL rvalid cyc=%0d got %b want %b", cyc, rvalid, erv); end
    checks++; if (rdata !== edat) begin errors++; $display("FAIL rdata cyc=%0d got %h want %h", cyc, rdata, edat); end
    g_o = gnt; rd_o = romRd; rv_o = rvalid; dat_o = rdata;
    @(posedge clk);
    if (rs) begin
      m_owner = -1;
      m_ptr = 0;
      ret_q.delete();
    end else begin
      if (a >= 0) begin
        e.due = cyc + L;
        e.idx = a;
        e.data = adr[a*AW +: AW] + 16'h0100;
        ret_q.push_back(e);
        m_ptr = (a + 1) % N;
      end
      if (m_owner >= 0) begin
        if (!l[m_owner]) m_owner = -1;
      end else if (a >= 0 && l[a]) begin
        m_owner = a;
      end
    end
    cyc++;
  endtask

  function automatic logic [N*AW-1:0] rnd_adr();
    return {16'($urandom), 16'($urandom), 16'($urandom)};
  endfunction

  task automatic idle(input int n);
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, rnd_adr(), g, rd, rv, d);
  endtask

  task automatic do_reset();
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    cycle(1'b1, '0, '0, '0, g, rd, rv, d);
    cycle(1'b1, '0, '0, '0, g, rd, rv, d);
  endtask

  task automatic test_reset();
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    do_reset();
    cycle(1'b0, '0, '0, rnd_adr(), g, rd, rv, d);
    checks++; if (g !== '0 || rd !== 1'b0) begin errors++; $display("FAIL reset_idle got gnt=%b romRd=%b want 000/0", g, rd); end
    checks++; if (rv !== '0 || d !== '0) begin errors++; $display("FAIL reset_ret got rvalid=%b rdata=%h want 000/0000", rv, d); end
  endtask

  task automatic test_single();
    logic [N-1:0] g, rv [6]; logic rd [6]; logic [DW-1:0] d [6];
    logic [N*AW-1:0] adr;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      adr = rnd_adr();
      adr[AW-1:0] = 16'h0010 + 16'(k);
      cycle(1'b0, (k < 3) ? 3'b001 : 3'b000, '0, adr, g, rd[k], rv[k], d[k]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++; if (rd[k] !== 1'b1) begin errors++; $display("FAIL single_rd k=%0d got %b want 1", k, rd[k]); end
      checks++; if (rv[k+L] !== 3'b001 || d[k+L] !== 16'h0110 + 16'(k)) begin errors++; $display("FAIL single_ret k=%0d got %b/%h want 001/%h", k, rv[k+L], d[k+L], 16'h0110 + 16'(k)); end
    end
  endtask

  task automatic test_wrap();
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    logic [N-1:0] want;
    do_reset();
    cycle(1'b0, 3'b100, '0, rnd_adr(), g, rd, rv, d);
    checks++; if (g !== 3'b100) begin errors++; $display("FAIL wrap_first got %b want 100", g); end
    for (int k = 0; k < 3; k++) begin
      want = 3'b001 << k;
      cycle(1'b0, 3'b111, '0, rnd_adr(), g, rd, rv, d);
      checks++; if (g !== want) begin errors++; $display("FAIL wrap_seq k=%0d got %b want %b", k, g, want); end
    end
  endtask

  task automatic test_contention();
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    logic [N-1:0] want;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      want = 3'b001 << (k % N);
      cycle(1'b0, 3'b111, '0, rnd_adr(), g, rd, rv, d);
      checks++; if (g !== want) begin errors++; $display("FAIL contention k=%0d got %b want %b", k, g, want); end
    end
    idle(L + 1);
  endtask

  task automatic test_lock();
    logic [N-1:0] g [6], rv; logic rd [6]; logic [DW-1:0] d;
    logic [N-1:0] rs_tab [6];
    logic [N-1:0] lk_tab [6];
    rs_tab = '{3'b010, 3'b011, 3'b001, 3'b011, 3'b011, 3'b011};
    lk_tab = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b000, 3'b000};
    do_reset();
    for (int k = 0; k < 6; k++) cycle(1'b0, rs_tab[k], lk_tab[k], rnd_adr(), g[k], rd[k], rv, d);
    for (int k = 1; k < 5; k++) begin
      checks++; if (g[k][0] !== 1'b0) begin errors++; $display("FAIL lock_hold k=%0d got gnt0=%b want 0", k, g[k][0]); end
    end
    checks++; if (rd[2] !== 1'b0) begin errors++; $display("FAIL lock_gap got romRd=%b want 0", rd[2]); end
    checks++; if (g[4] !== 3'b010) begin errors++; $display("FAIL lock_release_cycle got %b want 010", g[4]); end
    checks++; if (g[5] !== 3'b001) begin errors++; $display("FAIL lock_after got %b want 001", g[5]); end
    idle(L + 1);
  endtask

  task automatic test_latency();
    logic [N-1:0] g, rv [5]; logic rd; logic [DW-1:0] d [5];
    logic [N*AW-1:0] adr;
    adr = {16'h0300, 16'h0200, 16'h0100};
    do_reset();
    cycle(1'b0, 3'b001, '0, adr, g, rd, rv[0], d[0]);
    cycle(1'b0, 3'b010, '0, adr, g, rd, rv[1], d[1]);
    for (int k = 2; k < 5; k++) cycle(1'b0, '0, '0, adr, g, rd, rv[k], d[k]);
    checks++; if (rv[1] !== '0) begin errors++; $display("FAIL lat_early got %b want 000", rv[1]); end
    checks++; if (rv[2] !== 3'b001 || d[2] !== 16'h0200) begin errors++; $display("FAIL lat_r0 got %b/%h want 001/0200", rv[2], d[2]); end
    checks++; if (rv[3] !== 3'b010 || d[3] !== 16'h0300) begin errors++; $display("FAIL lat_r1 got %b/%h want 010/0300", rv[3], d[3]); end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    do_reset();
    cycle(1'b0, 3'b010, 3'b010, rnd_adr(), g, rd, rv, d);
    cycle(1'b1, '0, '0, rnd_adr(), g, rd, rv, d);
    cycle(1'b0, '0, '0, rnd_adr(), g, rd, rv, d);
    checks++; if (rv !== '0) begin errors++; $display("FAIL midflight_rvalid got %b want 000", rv); end
    cycle(1'b0, 3'b111, '0, rnd_adr(), g, rd, rv, d);
    checks++; if (g !== 3'b001) begin errors++; $display("FAIL midflight_first got %b want 001", g); end
    idle(L + 1);
  endtask

  task automatic test_random();
    logic [N-1:0] g, rv; logic rd; logic [DW-1:0] d;
    logic [N-1:0] r, l;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      r = N'($urandom);
      l = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      cycle(1'b0, r, l, rnd_adr(), g, rd, rv, d);
    end
    idle(L + 2);
  endtask

  initial begin
    rst = 1'b1; req = '0; lock = '0; reqAdr = '0;
    test_reset();
    test_single();
    test_wrap();
    test_contention();
    test_lock();
    test_latency();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
